// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the cache/memory arbiter: state encodings, grant codes
// and default block geometry used by icache, dcache and the arbiter.
package mem_arbiter_pkg;

  localparam int ADDR_W_DEF  = 6;
  localparam int BLOCK_W_DEF = 128;

  typedef enum logic [2:0] {
    ARB_IDLE    = 3'd0,
    ARB_I_ISSUE = 3'd1,
    ARB_I_WAIT  = 3'd2,
    ARB_D_ISSUE = 3'd3,
    ARB_D_WAIT  = 3'd4
  } arb_state_t;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  // On a tie the requester that was not served last wins.
  function automatic logic other_grant(input logic gnt);
    return ~gnt;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational two-way round-robin picker between the icache and dcache
// requests, using the last granted requester as the tie breaker.
module mem_arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic req_i,
  input  logic req_d,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_id
);

  always_comb begin
    grant_valid = req_i | req_d;
    grant_id    = GNT_I;
    if (req_i && req_d) begin
      grant_id = other_grant(last_grant);
    end else if (req_d) begin
      grant_id = GNT_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one block-wide main memory between the icache and the dcache, serving
// one requester at a time and stalling the other through its BUSYWAIT.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int BLOCK_W = BLOCK_W_DEF
) (
  input  logic               CLOCK,
  input  logic               RESET,
  input  logic               I_READ,
  input  logic [ADDR_W-1:0]  I_ADDRESS,
  output logic [BLOCK_W-1:0] I_READDATA,
  output logic               I_BUSYWAIT,
  input  logic               D_READ,
  input  logic               D_WRITE,
  input  logic [ADDR_W-1:0]  D_ADDRESS,
  input  logic [BLOCK_W-1:0] D_WRITEDATA,
  output logic [BLOCK_W-1:0] D_READDATA,
  output logic               D_BUSYWAIT,
  output logic               MEM_READ,
  output logic               MEM_WRITE,
  output logic [ADDR_W-1:0]  MEM_ADDRESS,
  output logic [BLOCK_W-1:0] MEM_WRITEDATA,
  input  logic [BLOCK_W-1:0] MEM_READDATA,
  input  logic               MEM_BUSYWAIT
);

  arb_state_t state, next_state;
  logic       last_grant;
  logic       i_req, d_req;
  logic       grant_valid, grant_id;

  assign i_req = I_READ;
  assign d_req = D_READ | D_WRITE;

  mem_arb_pick u_pick (
    .req_i       (i_req),
    .req_d       (d_req),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state      <= ARB_IDLE;
      last_grant <= GNT_I;
    end else begin
      state <= next_state;
      if (next_state == ARB_I_ISSUE) begin
        last_grant <= GNT_I;
      end else if (next_state == ARB_D_ISSUE) begin
        last_grant <= GNT_D;
      end
    end
  end

  // On completion the other side is granted straight away, without an idle cycle.
  always_comb begin
    next_state = state;
    case (state)
      ARB_IDLE: begin
        if (grant_valid) begin
          next_state = (grant_id == GNT_D) ? ARB_D_ISSUE : ARB_I_ISSUE;
        end
      end
      ARB_I_ISSUE: next_state = ARB_I_WAIT;
      ARB_I_WAIT: begin
        if (!MEM_BUSYWAIT) begin
          next_state = d_req ? ARB_D_ISSUE : ARB_IDLE;
        end
      end
      ARB_D_ISSUE: next_state = ARB_D_WAIT;
      ARB_D_WAIT: begin
        if (!MEM_BUSYWAIT) begin
          next_state = i_req ? ARB_I_ISSUE : ARB_IDLE;
        end
      end
      default: next_state = ARB_IDLE;
    endcase
  end

  // The request is captured only on entry to ISSUE; a write wins over a read
  // if the dcache raises both.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      MEM_READ      <= 1'b0;
      MEM_WRITE     <= 1'b0;
      MEM_ADDRESS   <= '0;
      MEM_WRITEDATA <= '0;
    end else begin
      case (next_state)
        ARB_I_ISSUE: begin
          MEM_READ    <= 1'b1;
          MEM_WRITE   <= 1'b0;
          MEM_ADDRESS <= I_ADDRESS;
        end
        ARB_D_ISSUE: begin
          MEM_READ      <= ~D_WRITE;
          MEM_WRITE     <= D_WRITE;
          MEM_ADDRESS   <= D_ADDRESS;
          MEM_WRITEDATA <= D_WRITEDATA;
        end
        ARB_IDLE: begin
          MEM_READ  <= 1'b0;
          MEM_WRITE <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  assign I_BUSYWAIT = ~RESET & i_req & ~((state == ARB_I_WAIT) & ~MEM_BUSYWAIT);
  assign D_BUSYWAIT = ~RESET & d_req & ~((state == ARB_D_WAIT) & ~MEM_BUSYWAIT);

  assign I_READDATA = MEM_READDATA;
  assign D_READDATA = MEM_READDATA;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: table-driven grant vectors, hand-written
// corner sequences and a randomized two-cache workload against a reference memory.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int AW       = 6;
  localparam int BW       = 128;
  localparam int WAIT_MAX = 16;

  logic          CLOCK = 1'b0;
  logic          RESET = 1'b0;
  logic          I_READ, D_READ, D_WRITE;
  logic [AW-1:0] I_ADDRESS, D_ADDRESS, MEM_ADDRESS;
  logic [BW-1:0] I_READDATA, D_READDATA, D_WRITEDATA, MEM_WRITEDATA, MEM_READDATA;
  logic          I_BUSYWAIT, D_BUSYWAIT, MEM_READ, MEM_WRITE, MEM_BUSYWAIT;

  always #5 CLOCK = ~CLOCK;

  mem_arbiter #(.ADDR_W(AW), .BLOCK_W(BW)) dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .I_READ(I_READ), .I_ADDRESS(I_ADDRESS), .I_READDATA(I_READDATA), .I_BUSYWAIT(I_BUSYWAIT),
    .D_READ(D_READ), .D_WRITE(D_WRITE), .D_ADDRESS(D_ADDRESS), .D_WRITEDATA(D_WRITEDATA),
    .D_READDATA(D_READDATA), .D_BUSYWAIT(D_BUSYWAIT),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
    .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
  );

  int checks = 0;
  int errors = 0;

  function automatic logic [BW-1:0] init_pattern(input int a);
    return {32'hC0DE0000 + a, 32'h5A5A0000 + a * 3, 32'h0F0F0000 ^ a, 32'hBEEF0000 + a * 7};
  endfunction

  // Memory stand-in: busy rises the cycle after a strobe is seen, stays high
  // mem_lat cycles, and ignores the strobe still present right after completion.
  logic [BW-1:0] mem [0:63];
  logic [BW-1:0] ref_mem [0:63];
  logic          busy = 1'b0, done = 1'b0, init_done = 1'b0;
  int            cnt, mem_lat, log_n, done_n;
  logic          cur_wr, last_wr;
  logic [AW-1:0] cur_a, last_a;
  logic [BW-1:0] cur_d, last_d, rdata;
  logic          log_wr [0:63];
  logic [AW-1:0] log_a [0:63];

  assign MEM_BUSYWAIT = busy;
  assign MEM_READDATA = rdata;

  always @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      busy <= 1'b0;
      done <= 1'b0;
      cnt  <= 0;
      if (!init_done) begin
        for (int k = 0; k < 64; k++) mem[k] <= init_pattern(k);
        log_n     <= 0;
        done_n    <= 0;
        init_done <= 1'b1;
      end
    end else if (busy) begin
      if (cnt <= 1) begin
        busy    <= 1'b0;
        done    <= 1'b1;
        done_n  <= done_n + 1;
        last_wr <= cur_wr;
        last_a  <= cur_a;
        last_d  <= cur_d;
        if (cur_wr) mem[cur_a] <= cur_d;
        else rdata <= mem[cur_a];
      end else begin
        cnt <= cnt - 1;
      end
    end else if (done) begin
      done <= 1'b0;
    end else if (MEM_READ || MEM_WRITE) begin
      busy   <= 1'b1;
      cnt    <= mem_lat;
      cur_wr <= MEM_WRITE;
      cur_a  <= MEM_ADDRESS;
      cur_d  <= MEM_WRITEDATA;
      if (log_n < 64) begin
        log_wr[log_n] <= MEM_WRITE;
        log_a[log_n]  <= MEM_ADDRESS;
      end
      log_n <= log_n + 1;
    end
  end

  typedef struct {
    logic       i_rd;
    logic       d_rd;
    logic       d_wr;
    logic [5:0] i_a;
    logic [5:0] d_a;
    int         exp_n;
    logic       exp0_wr;
    logic [5:0] exp0_a;
    logic [5:0] exp1_a;
  } vec_t;

  vec_t vecs [0:6];
  int   i_wait, d_wait, i_gap, d_gap;

  task automatic checkOutput(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge CLOCK);
    I_READ  = 1'b0;
    D_READ  = 1'b0;
    D_WRITE = 1'b0;
    RESET   = 1'b1;
    @(negedge CLOCK);
    RESET = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    int base;
    int c;
    do_reset();
    base        = log_n;
    I_READ      = v.i_rd;
    D_READ      = v.d_rd;
    D_WRITE     = v.d_wr;
    I_ADDRESS   = v.i_a;
    D_ADDRESS   = v.d_a;
    D_WRITEDATA = {4{32'h70000000 + idx}};
    c = 0;
    while ((I_READ || D_READ || D_WRITE) && c < 60) begin
      @(negedge CLOCK);
      c++;
      if (I_READ && !I_BUSYWAIT) I_READ = 1'b0;
      if ((D_READ || D_WRITE) && !D_BUSYWAIT) begin
        D_READ  = 1'b0;
        D_WRITE = 1'b0;
      end
    end
    checkOutput($sformatf("vec%0d finished", idx), I_READ | D_READ | D_WRITE, 0);
    if (v.d_wr) ref_mem[v.d_a] = D_WRITEDATA;
    repeat (3) @(negedge CLOCK);
    checkOutput($sformatf("vec%0d txn count", idx), log_n - base, v.exp_n);
    if (v.exp_n >= 1) begin
      checkOutput($sformatf("vec%0d first write", idx), log_wr[base], v.exp0_wr);
      checkOutput($sformatf("vec%0d first addr", idx), log_a[base], v.exp0_a);
    end
    if (v.exp_n == 2) checkOutput($sformatf("vec%0d second addr", idx), log_a[base + 1], v.exp1_a);
  endtask

  task automatic rnd_step(input bit allow_new);
    @(negedge CLOCK);
    mem_lat = $urandom_range(1, 4);
    if (I_READ && (D_READ || D_WRITE))
      checkOutput("rnd exclusive", (!I_BUSYWAIT && !D_BUSYWAIT), 0);
    if (I_READ) begin
      if (!I_BUSYWAIT) begin
        checkOutput("rnd i data", I_READDATA, ref_mem[I_ADDRESS]);
        checkOutput("rnd i txn", {last_wr, last_a}, {1'b0, I_ADDRESS});
        checkOutput("rnd i wait", i_wait > WAIT_MAX, 0);
        I_READ = 1'b0;
        i_gap  = $urandom_range(0, 2);
      end else i_wait++;
    end else if (i_gap > 0) i_gap--;
    else if (allow_new && $urandom_range(0, 1) == 1) begin
      I_READ    = 1'b1;
      I_ADDRESS = 6'($urandom_range(0, 63));
      i_wait    = 0;
    end
    if (D_READ || D_WRITE) begin
      if (!D_BUSYWAIT) begin
        if (D_WRITE) begin
          checkOutput("rnd d wr txn", {last_wr, last_a}, {1'b1, D_ADDRESS});
          checkOutput("rnd d wr data", last_d, D_WRITEDATA);
          ref_mem[D_ADDRESS] = D_WRITEDATA;
        end else begin
          checkOutput("rnd d rd data", D_READDATA, ref_mem[D_ADDRESS]);
          checkOutput("rnd d rd txn", {last_wr, last_a}, {1'b0, D_ADDRESS});
        end
        checkOutput("rnd d wait", d_wait > WAIT_MAX, 0);
        D_READ  = 1'b0;
        D_WRITE = 1'b0;
        d_gap   = $urandom_range(0, 2);
      end else d_wait++;
    end else if (d_gap > 0) d_gap--;
    else if (allow_new && $urandom_range(0, 1) == 1) begin
      D_WRITE     = ($urandom_range(0, 1) == 1);
      D_READ      = !D_WRITE;
      D_ADDRESS   = 6'($urandom_range(0, 63));
      D_WRITEDATA = {$urandom, $urandom, $urandom, $urandom};
      d_wait      = 0;
    end
  endtask

  initial begin
    int c, base, bad, bad2, base_d;
    logic [BW-1:0] w;
    for (int k = 0; k < 64; k++) ref_mem[k] = init_pattern(k);
    vecs[0] = '{1'b1, 1'b0, 1'b0, 6'h05, 6'h00, 1, 1'b0, 6'h05, 6'h00};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 6'h00, 6'h08, 1, 1'b0, 6'h08, 6'h00};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 6'h00, 6'h09, 1, 1'b1, 6'h09, 6'h00};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 6'h01, 6'h02, 2, 1'b0, 6'h02, 6'h01};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 6'h03, 6'h04, 2, 1'b1, 6'h04, 6'h03};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 6'h00, 6'h2A, 1, 1'b1, 6'h2A, 6'h00};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 6'h00, 6'h00, 0, 1'b0, 6'h00, 6'h00};

    I_READ = 1'b1; D_READ = 1'b0; D_WRITE = 1'b1;
    I_ADDRESS = 6'h3F; D_ADDRESS = 6'h3E; D_WRITEDATA = '1;
    mem_lat = 3;
    #2 RESET = 1'b1;
    #1;
    checkOutput("reset mem_read", MEM_READ, 0);
    checkOutput("reset mem_write", MEM_WRITE, 0);
    checkOutput("reset mem_address", MEM_ADDRESS, 0);
    checkOutput("reset mem_writedata", MEM_WRITEDATA, 0);
    checkOutput("reset i_busywait", I_BUSYWAIT, 0);
    checkOutput("reset d_busywait", D_BUSYWAIT, 0);

    // Reset in the middle of a dcache write-back.
    do_reset();
    I_READ = 1'b1; D_WRITE = 1'b1;
    c = 0;
    while (!MEM_BUSYWAIT && c < 20) begin @(negedge CLOCK); c++; end
    checkOutput("t1 reached d_wait", MEM_WRITE & MEM_BUSYWAIT, 1);
    #2 RESET = 1'b1;
    #1;
    checkOutput("t1 mem_write dropped", MEM_WRITE, 0);
    checkOutput("t1 mem_read dropped", MEM_READ, 0);
    checkOutput("t1 i_busywait", I_BUSYWAIT, 0);
    checkOutput("t1 d_busywait", D_BUSYWAIT, 0);
    @(negedge CLOCK);
    RESET = 1'b0;
    @(negedge CLOCK);
    checkOutput("t1 d first after reset", {MEM_WRITE, MEM_READ}, 2'b10);

    for (int i = 0; i < 7; i++) applyStimulus(vecs[i], i);

    // Lone icache read, 5-cycle memory.
    do_reset();
    mem_lat = 5;
    I_READ = 1'b1; I_ADDRESS = 6'h05;
    @(negedge CLOCK);
    checkOutput("t2 issue read", {MEM_READ, MEM_WRITE}, 2'b10);
    checkOutput("t2 issue addr", MEM_ADDRESS, 6'h05);
    c = 1; bad = 0; bad2 = 0;
    while (I_BUSYWAIT && c < 30) begin
      if (D_BUSYWAIT) bad = 1;
      if (MEM_READ && MEM_ADDRESS != 6'h05) bad2 = 1;
      @(negedge CLOCK);
      c++;
    end
    checkOutput("t2 latency", c, 7);
    checkOutput("t2 readdata", I_READDATA, ref_mem[5]);
    checkOutput("t2 d_busywait quiet", bad | D_BUSYWAIT, 0);
    checkOutput("t2 address stable", bad2, 0);
    I_READ = 1'b0;
    @(negedge CLOCK);
    checkOutput("t2 strobe dropped", MEM_READ, 0);

    // Simultaneous I read and D write-back: D first, then I without a bubble.
    do_reset();
    mem_lat = 3;
    w = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    I_READ = 1'b1; I_ADDRESS = 6'h07;
    D_WRITE = 1'b1; D_ADDRESS = 6'h09; D_WRITEDATA = w;
    @(negedge CLOCK);
    checkOutput("t3 d write strobe", {MEM_WRITE, MEM_READ}, 2'b10);
    checkOutput("t3 d write addr", MEM_ADDRESS, 6'h09);
    checkOutput("t3 d write data", MEM_WRITEDATA, w);
    c = 0; bad = 0;
    while (D_BUSYWAIT && c < 30) begin
      if (!I_BUSYWAIT) bad = 1;
      @(negedge CLOCK);
      c++;
    end
    checkOutput("t3 d completed", D_BUSYWAIT, 0);
    checkOutput("t3 i held during d", bad | !I_BUSYWAIT, 0);
    D_WRITE = 1'b0;
    ref_mem[9] = w;
    @(negedge CLOCK);
    checkOutput("t3 i issue no bubble", {MEM_READ, MEM_WRITE}, 2'b10);
    checkOutput("t3 i issue addr", MEM_ADDRESS, 6'h07);
    c = 0;
    while (I_BUSYWAIT && c < 30) begin @(negedge CLOCK); c++; end
    checkOutput("t3 i readdata", I_READDATA, ref_mem[7]);
    checkOutput("t3 memory updated", mem[9], w);
    I_READ = 1'b0;

    // Continuous contention: grants alternate starting with D.
    do_reset();
    mem_lat = 2;
    base = log_n;
    w = {4{32'h44332211}};
    I_READ = 1'b1; I_ADDRESS = 6'h11;
    D_WRITE = 1'b1; D_ADDRESS = 6'h12; D_WRITEDATA = w;
    c = 0;
    while (log_n - base < 6 && c < 200) begin @(negedge CLOCK); c++; end
    D_WRITE = 1'b0;
    c = 0;
    while (I_BUSYWAIT && c < 40) begin @(negedge CLOCK); c++; end
    I_READ = 1'b0;
    ref_mem[6'h12] = w;
    checkOutput("t4 six grants", log_n - base >= 6, 1);
    for (int k = 0; k < 6; k++)
      checkOutput($sformatf("t4 grant%0d is_d", k), log_wr[base + k], (k % 2) == 0);
    repeat (2) @(negedge CLOCK);

    // icache request withdrawn while its read is in flight.
    do_reset();
    mem_lat = 4;
    base = log_n; base_d = done_n;
    I_READ = 1'b1; I_ADDRESS = 6'h03;
    c = 0;
    while (!MEM_BUSYWAIT && c < 20) begin @(negedge CLOCK); c++; end
    checkOutput("t5 reached i_wait", MEM_BUSYWAIT & MEM_READ, 1);
    I_READ = 1'b0;
    c = 0; bad = 0;
    while (done_n == base_d && c < 20) begin
      @(negedge CLOCK);
      c++;
      if (I_BUSYWAIT) bad = 1;
    end
    checkOutput("t5 read completed", done_n - base_d, 1);
    @(negedge CLOCK);
    checkOutput("t5 idle after", MEM_READ, 0);
    repeat (3) begin
      @(negedge CLOCK);
      if (I_BUSYWAIT || MEM_READ) bad = 1;
    end
    checkOutput("t5 no busywait", bad, 0);
    checkOutput("t5 single txn", log_n - base, 1);

    // dcache address changes during its wait; memory address must not follow.
    do_reset();
    mem_lat = 4;
    D_READ = 1'b1; D_ADDRESS = 6'h10;
    c = 0;
    while (!MEM_BUSYWAIT && c < 20) begin @(negedge CLOCK); c++; end
    D_ADDRESS = 6'h22;
    c = 0; bad = 0;
    while (D_BUSYWAIT && c < 30) begin
      if (MEM_ADDRESS != 6'h10) bad = 1;
      @(negedge CLOCK);
      c++;
    end
    checkOutput("t6 address held", bad, 0);
    checkOutput("t6 final address", MEM_ADDRESS, 6'h10);
    checkOutput("t6 readdata", D_READDATA, ref_mem[6'h10]);
    D_READ = 1'b0;

    // Randomized two-cache workload.
    do_reset();
    i_wait = 0; d_wait = 0; i_gap = 0; d_gap = 0;
    for (int n = 0; n < 500; n++) rnd_step(1'b1);
    for (int n = 0; n < 80; n++) rnd_step(1'b0);
    checkOutput("rnd drained", I_READ | D_READ | D_WRITE, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
